axi_wr_burst_arbiter: RTL

- Shares one AXI write slave port (AW + W channels) among 4 masters, using round-robin arbitration.
- The grant is locked for a full burst, from the AW handshake through the W beat carrying WLAST, then released for re-arbitration.
- Sits in the AXI interconnect between master-side ports and one slave port.
- Also checks the burst beat count against AWLEN.

---
 rtl/axi_wr_burst_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/axi_wr_burst_arbiter.sv
// Round-robin arbiter sharing one AXI write slave port (AW + W) among four masters.
// The grant is held from the AW handshake through the WLAST beat; beat counts are checked against AWLEN.
module axi_wr_burst_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            m_awvalid,
    input  logic [4*ADDR_W-1:0]   m_awaddr,
    input  logic [4*8-1:0]        m_awlen,
    output logic [3:0]            m_awready,
    input  logic [3:0]            m_wvalid,
    input  logic [4*DATA_W-1:0]   m_wdata,
    input  logic [4*STRB_W-1:0]   m_wstrb,
    input  logic [3:0]            m_wlast,
    output logic [3:0]            m_wready,
    output logic                  s_awvalid,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [7:0]            s_awlen,
    output logic [1:0]            s_awid,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [STRB_W-1:0]     s_wstrb,
    output logic                  s_wlast,
    input  logic                  s_wready,
    output logic [3:0]            grant,
    output logic                  busy,
    output logic                  len_err
);

    typedef enum logic [1:0] {S_IDLE, S_AW, S_WDATA} state_t;

    state_t     state, state_nxt;
    logic [3:0] grant_nxt;
    logic [3:0] last_winner;
    logic [3:0] winner;
    logic [1:0] g;
    logic [7:0] beat_cnt;
    logic [7:0] awlen_q;
    logic       ovf_q;
    logic       aw_hs;
    logic       w_hs;

    always_comb begin
        g = 2'd0;
        for (int i = 0; i < 4; i++)
            if (grant[i]) g = 2'(i);
    end

    // Search begins one past the previous winner; an empty last_winner starts at master 0.
    always_comb begin
        logic [1:0] start;
        logic [1:0] idx;
        logic       found;
        winner = 4'b0000;
        start  = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++)
            if (last_winner[i]) start = 2'(i + 1);
        for (int j = 0; j < 4; j++) begin
            idx = start + 2'(j);
            if (!found && m_awvalid[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        m_awready = 4'b0000;
        m_wready  = 4'b0000;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = 8'd0;
        s_awid    = 2'd0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        case (state)
            S_AW: begin
                s_awvalid    = m_awvalid[g];
                s_awaddr     = m_awaddr[g*ADDR_W +: ADDR_W];
                s_awlen      = m_awlen[g*8 +: 8];
                s_awid       = g;
                m_awready[g] = s_awready;
            end
            S_WDATA: begin
                s_wvalid    = m_wvalid[g];
                s_wdata     = m_wdata[g*DATA_W +: DATA_W];
                s_wstrb     = m_wstrb[g*STRB_W +: STRB_W];
                s_wlast     = m_wlast[g];
                m_wready[g] = s_wready;
            end
            default: ;
        endcase
    end

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign busy  = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            S_IDLE: begin
                if (|m_awvalid) begin
                    grant_nxt = winner;
                    state_nxt = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) state_nxt = S_WDATA;
            end
            S_WDATA: begin
                if (w_hs && s_wlast) begin
                    grant_nxt = 4'b0000;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                grant_nxt = 4'b0000;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            grant <= 4'b0000;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // ovf_q remembers an overrun already flagged so the closing WLAST does not flag it twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 4'b0000;
            beat_cnt    <= 8'd0;
            awlen_q     <= 8'd0;
            ovf_q       <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (aw_hs) begin
                last_winner <= grant;
                beat_cnt    <= 8'd0;
                awlen_q     <= s_awlen;
                ovf_q       <= 1'b0;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (!ovf_q) begin
                    if (s_wlast && (beat_cnt != awlen_q))
                        len_err <= 1'b1;
                    if (!s_wlast && (beat_cnt == awlen_q)) begin
                        len_err <= 1'b1;
                        ovf_q   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
